// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, byte-enable
// constants, bus widths and the latched request payload.
package dmem_responder_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WORD_AW = ADDR_W - 2;

    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised storage with per-byte-lane synchronous write and a registered
// synchronous read port; contents are never cleared, only the read register is.
module dmem_ram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              clr,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Lane-masked write commit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds the response word until the next access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end else if (clr) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request, waits LATENCY
// cycles, commits/samples storage once, holds the response until taken.
// Optional misaligned-address trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned      AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [WORD_AW-1:0] DEPTH_LIM = WORD_AW'(DEPTH_WORDS);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    req_t             req_in;
    req_t             req_q;
    req_t             cur;
    logic             accept;
    logic             commit;
    logic             addr_err;
    logic             mis_err;
    logic             req_err;
    logic             ram_wr_en;
    logic             ram_rd_en;
    logic             ram_clr;

    assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    assign accept = req_valid & req_ready;

    // A single-cycle latency commits on the accept edge, before req_q is loaded.
    assign cur = (state == IDLE) ? req_in : req_q;

    assign addr_err = (cur.addr[ADDR_W-1:2] >= DEPTH_LIM);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_err = |cur.addr[1:0];
`else
    logic unused_addr_lsb;
    assign mis_err         = 1'b0;
    assign unused_addr_lsb = ^cur.addr[1:0];
`endif

    assign req_err = addr_err | mis_err;

    // Next-state, counter and commit strobe.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY <= 1) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            if (accept) begin
                req_q <= req_in;
            end
            if (commit) begin
                rsp_err <= req_err;
            end
        end
    end

    // Faulted requests never touch storage; writes and faults answer with zero data.
    assign ram_wr_en = commit &  cur.we & ~req_err;
    assign ram_rd_en = commit & ~cur.we & ~req_err;
    assign ram_clr   = commit & (cur.we | req_err);

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .wr_en (ram_wr_en),
        .rd_en (ram_rd_en),
        .clr   (ram_clr),
        .addr  (cur.addr[AW+1:2]),
        .wdata (cur.wdata),
        .be    (cur.be),
        .rdata (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .LATENCY     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Present a request once req_ready is seen; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (ok) begin
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = addr;
            req_wdata = wdata;
            req_be    = be;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            req_we    = 1'b0;
            req_addr  = '0;
            req_wdata = '0;
            req_be    = '0;
        end
    endtask

    // Counts clock edges after the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rd, output logic er,
                            output int lat);
        bit ok;
        issue(we, addr, wdata, be, ok);
        if (!ok) begin
            lat = 99;
            rd  = 'x;
            er  = 1'bx;
        end else begin
            wait_rsp(lat);
            rd = rsp_rdata;
            er = rsp_err;
            take_rsp();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        vectors++; if (rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
        vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h10, 32'hDEADBEEF, BE_WORD, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d want 2", lat); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b want 0", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL wr_rdata: got %h want 0", rd); end
        transact(1'b0, 32'h10, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d want 2", lat); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rd_err: got %b want 0", er); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
        transact(1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        vectors++; if (rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL lane0_merge: got %h want deadbeaa", rd); end
        transact(1'b1, 32'h14, 32'hFFFFFFFF, BE_WORD, rd, er, lat);
        transact(1'b1, 32'h14, 32'h11223344, BE_HALF_HI, rd, er, lat);
        transact(1'b0, 32'h14, 32'h0, BE_HALF_LO, rd, er, lat);
        vectors++; if (rd !== 32'h1122FFFF) begin miscompares++; $display("FAIL half_hi_merge: got %h want 1122ffff", rd); end
        transact(1'b1, 32'h14, 32'h00000000, 4'b0000, rd, er, lat);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL be0_err: got %b want 0", er); end
        transact(1'b0, 32'h14, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (rd !== 32'h1122FFFF) begin miscompares++; $display("FAIL be0_noop: got %h want 1122ffff", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        transact(1'b1, 32'h0, 32'hCAFEF00D, BE_WORD, rd, er, lat);
        transact(1'b0, 32'h1000, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL oor_latency: got %0d want 2", lat); end
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL oor_rd_err: got %b want 1", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oor_rd_data: got %h want 0", rd); end
        transact(1'b1, 32'h1000, 32'h55555555, BE_WORD, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL oor_wr_err: got %b want 1", er); end
        transact(1'b0, 32'h0, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL oor_word0_intact: got %h want cafef00d", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL word0_err: got %b want 0", er); end
        transact(1'b1, 32'hFFC, 32'h0F0F0F0F, BE_WORD, rd, er, lat);
        transact(1'b0, 32'hFFC, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (er !== 1'b0 || rd !== 32'h0F0F0F0F) begin miscompares++; $display("FAIL last_word: got err=%b data=%h want err=0 data=0f0f0f0f", er, rd); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic er; int lat; bit ok;
        issue(1'b0, 32'h10, 32'h0, BE_WORD, ok);
        wait_rsp(lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL stall_latency: got %0d want 2", lat); end
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h99999999; req_be = BE_WORD;
        for (int c = 0; c < 5; c++) begin
            vectors++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEAA || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold cyc%0d: got valid=%b data=%h ready=%b want 1/deadbeaa/0", c, rsp_valid, rsp_rdata, req_ready);
            end
            if (c < 4) @(negedge clk);
        end
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release: got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        transact(1'b0, 32'h10, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL ignored_req: got %h want deadbeaa", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit ok;
        transact(1'b1, 32'h20, 32'h0BADC0DE, BE_WORD, rd, er, lat);
        issue(1'b1, 32'h20, 32'h12345678, BE_WORD, ok);
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs: got valid=%b ready=%b want 0/0", rsp_valid, req_ready); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid); end
        transact(1'b0, 32'h20, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (rd !== 32'h0BADC0DE) begin miscompares++; $display("FAIL midrst_old_value: got %h want 0badc0de", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        transact(1'b0, 32'h13, 32'h0, BE_WORD, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL mis_latency: got %0d want 2", lat); end
`ifdef DMEM_MISALIGN_TRAP_EN
        vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL mis_trap: got err=%b data=%h want 1/0", er, rd); end
`else
        vectors++; if (er !== 1'b0 || rd !== 32'hDEADBEAA) begin miscompares++; $display("FAIL mis_aligned: got err=%b data=%h want 0/deadbeaa", er, rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_out_of_range();
        test_stall();
        test_reset_mid();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
